// File: rtl/branch_predictor_bht_pkg.sv
// Shared types and helpers for the BHT branch predictor: counter type,
// indexing-mode enum and saturating counter arithmetic.
package bp_pkg;

    localparam int CTR_W_MAX = 8;

    typedef logic [CTR_W_MAX-1:0] ctr_t;

    typedef enum logic {
        BP_BIMODAL = 1'b0,
        BP_GSHARE  = 1'b1
    } bp_mode_e;

    // Counters narrower than ctr_t live in the low bits; w selects the real width.
    function automatic ctr_t ctr_wnt(input int w);
        return (ctr_t'(1) << (w - 1)) - ctr_t'(1);
    endfunction

    function automatic ctr_t ctr_wt(input int w);
        return ctr_t'(1) << (w - 1);
    endfunction

    function automatic ctr_t sat_inc(input ctr_t v, input int w);
        ctr_t maxVal;
        maxVal = (ctr_t'(1) << w) - ctr_t'(1);
        return (v == maxVal) ? v : v + ctr_t'(1);
    endfunction

    function automatic ctr_t sat_dec(input ctr_t v, input int w);
        return (v == '0) ? v : v - ctr_t'(1);
    endfunction

endpackage

// File: rtl/branch_predictor_bht_if.sv
// Fetch-lookup, resolution and performance signals between the pipeline
// (master) and the branch predictor (slave).
interface branch_predictor_bht_if #(
    parameter int XLEN   = 32,
    parameter int IDX_W  = 4,
    parameter int PERF_W = 32
);
    logic              if_valid;
    logic              if_stall;
    logic [XLEN-1:0]   if_pc;
    logic              pred_hit;
    logic              pred_taken;
    logic [XLEN-1:0]   pred_target;
    logic [IDX_W-1:0]  pred_ghr;

    logic              upd_valid;
    logic              upd_is_branch;
    logic [XLEN-1:0]   upd_pc;
    logic              upd_taken;
    logic [XLEN-1:0]   upd_target;
    logic              upd_pred_taken;
    logic [XLEN-1:0]   upd_pred_target;
    logic [IDX_W-1:0]  upd_ghr;
    logic              mispredict;
    logic [XLEN-1:0]   redirect_pc;

    logic [PERF_W-1:0] perf_lookups;
    logic [PERF_W-1:0] perf_mispredicts;

    modport master (
        output if_valid, if_stall, if_pc,
        output upd_valid, upd_is_branch, upd_pc, upd_taken, upd_target,
        output upd_pred_taken, upd_pred_target, upd_ghr,
        input  pred_hit, pred_taken, pred_target, pred_ghr,
        input  mispredict, redirect_pc, perf_lookups, perf_mispredicts
    );

    modport slave (
        input  if_valid, if_stall, if_pc,
        input  upd_valid, upd_is_branch, upd_pc, upd_taken, upd_target,
        input  upd_pred_taken, upd_pred_target, upd_ghr,
        output pred_hit, pred_taken, pred_target, pred_ghr,
        output mispredict, redirect_pc, perf_lookups, perf_mispredicts
    );

endinterface

// File: rtl/branch_predictor_bht_entry_table.sv
// Direct-mapped predictor storage: valid/tag/target/counter per entry, one
// combinational read port and one training write port with read-modify-write.
module bp_entry_table
    import bp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = XLEN - IDX_W - 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [XLEN-1:0]  rd_target_o,
    output logic             rd_ctr_msb_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic             wr_taken_i,
    input  logic [XLEN-1:0]  wr_target_i
);

    localparam ctr_t CTR_WNT = ctr_wnt(CTR_W);
    localparam ctr_t CTR_WT  = ctr_wt(CTR_W);

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [XLEN-1:0]    target_d [ENTRIES];
    logic [CTR_W-1:0]   ctr_q    [ENTRIES];
    logic [CTR_W-1:0]   ctr_d    [ENTRIES];

    logic wr_hit;
    ctr_t wr_ctr_ext;

    assign rd_valid_o   = valid_q[rd_idx_i];
    assign rd_tag_o     = tag_q[rd_idx_i];
    assign rd_target_o  = target_q[rd_idx_i];
    assign rd_ctr_msb_o = ctr_q[rd_idx_i][CTR_W-1];

    assign wr_hit     = valid_q[wr_idx_i] && (tag_q[wr_idx_i] == wr_tag_i);
    assign wr_ctr_ext = ctr_t'(ctr_q[wr_idx_i]);

    // A not-taken branch that misses leaves the table alone; only taken misses allocate.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (wr_en_i) begin
            if (wr_hit) begin
                if (wr_taken_i) begin
                    ctr_d[wr_idx_i]    = CTR_W'(sat_inc(wr_ctr_ext, CTR_W));
                    target_d[wr_idx_i] = wr_target_i;
                end else begin
                    ctr_d[wr_idx_i]    = CTR_W'(sat_dec(wr_ctr_ext, CTR_W));
                end
            end else if (wr_taken_i) begin
                valid_d[wr_idx_i]  = 1'b1;
                tag_d[wr_idx_i]    = wr_tag_i;
                target_d[wr_idx_i] = wr_target_i;
                ctr_d[wr_idx_i]    = CTR_WT[CTR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT[CTR_W-1:0];
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

endmodule

// File: rtl/branch_predictor_bht.sv
// Dynamic branch predictor top: bimodal/gshare indexing, global history,
// mispredict/redirect generation and saturating performance counters.
module branch_predictor_bht
    import bp_pkg::*;
#(
    parameter int       XLEN    = 32,
    parameter int       ENTRIES = 16,
    parameter int       CTR_W   = 2,
    parameter bp_mode_e MODE    = BP_BIMODAL,
    parameter int       PERF_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    branch_predictor_bht_if.slave  bus
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic [IDX_W-1:0]  ghr_q, ghr_d;
    logic [PERF_W-1:0] lookups_q, lookups_d;
    logic [PERF_W-1:0] mispredicts_q, mispredicts_d;

    logic [IDX_W-1:0]  fetch_hash, upd_hash;
    logic [IDX_W-1:0]  fetch_idx, upd_idx;
    logic [TAG_W-1:0]  fetch_tag, upd_tag;
    logic              rd_valid, rd_ctr_msb;
    logic [TAG_W-1:0]  rd_tag;
    logic [XLEN-1:0]   rd_target;
    logic              hit, taken, train, mispredict, fetch_fire;
    logic [IDX_W-1:0]  ghr_spec, ghr_restore;

    assign fetch_hash = (MODE == BP_GSHARE) ? ghr_q       : '0;
    assign upd_hash   = (MODE == BP_GSHARE) ? bus.upd_ghr : '0;
    assign fetch_idx  = bus.if_pc[IDX_W+1:2] ^ fetch_hash;
    assign upd_idx    = bus.upd_pc[IDX_W+1:2] ^ upd_hash;
    assign fetch_tag  = bus.if_pc[XLEN-1:IDX_W+2];
    assign upd_tag    = bus.upd_pc[XLEN-1:IDX_W+2];

    bp_entry_table #(
        .XLEN    (XLEN),
        .ENTRIES (ENTRIES),
        .CTR_W   (CTR_W),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W)
    ) u_table (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_idx_i     (fetch_idx),
        .rd_valid_o   (rd_valid),
        .rd_tag_o     (rd_tag),
        .rd_target_o  (rd_target),
        .rd_ctr_msb_o (rd_ctr_msb),
        .wr_en_i      (train),
        .wr_idx_i     (upd_idx),
        .wr_tag_i     (upd_tag),
        .wr_taken_i   (bus.upd_taken),
        .wr_target_i  (bus.upd_target)
    );

    // Lookup reads pre-update state: a same-cycle training write is visible next cycle.
    assign hit        = rd_valid && (rd_tag == fetch_tag);
    assign taken      = hit && rd_ctr_msb;
    assign fetch_fire = bus.if_valid && !bus.if_stall;

    assign bus.pred_hit    = hit;
    assign bus.pred_taken  = taken;
    assign bus.pred_target = taken ? rd_target : bus.if_pc + XLEN'(4);
    assign bus.pred_ghr    = ghr_q;

    assign train      = bus.upd_valid && bus.upd_is_branch;
    assign mispredict = train &&
                        ((bus.upd_taken != bus.upd_pred_taken) ||
                         (bus.upd_taken && (bus.upd_target != bus.upd_pred_target)));

    assign bus.mispredict  = mispredict;
    assign bus.redirect_pc = bus.upd_taken ? bus.upd_target : bus.upd_pc + XLEN'(4);

    generate
        if (IDX_W > 1) begin : g_ghr_shift
            assign ghr_spec    = {ghr_q[IDX_W-2:0], taken};
            assign ghr_restore = {bus.upd_ghr[IDX_W-2:0], bus.upd_taken};
        end else begin : g_ghr_bit
            assign ghr_spec    = taken;
            assign ghr_restore = bus.upd_taken;
        end
    endgenerate

    // A mispredict repairs history from the branch's snapshot and wins over speculation.
    always_comb begin
        ghr_d = ghr_q;
        if (MODE != BP_GSHARE) begin
            ghr_d = '0;
        end else if (mispredict) begin
            ghr_d = ghr_restore;
        end else if (fetch_fire && hit) begin
            ghr_d = ghr_spec;
        end
    end

    always_comb begin
        lookups_d     = lookups_q;
        mispredicts_d = mispredicts_q;
        if (fetch_fire && (lookups_q != '1)) begin
            lookups_d = lookups_q + PERF_W'(1);
        end
        if (mispredict && (mispredicts_q != '1)) begin
            mispredicts_d = mispredicts_q + PERF_W'(1);
        end
    end

    assign bus.perf_lookups     = lookups_q;
    assign bus.perf_mispredicts = mispredicts_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q         <= '0;
            lookups_q     <= '0;
            mispredicts_q <= '0;
        end else begin
            ghr_q         <= ghr_d;
            lookups_q     <= lookups_d;
            mispredicts_q <= mispredicts_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht: a bimodal and a gshare instance
// receive identical stimulus; each phase checks the instance it targets.
module tb_branch_predictor_bht;
    import bp_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    branch_predictor_bht_if #(.XLEN(32), .IDX_W(4), .PERF_W(32)) b0 ();
    branch_predictor_bht_if #(.XLEN(32), .IDX_W(4), .PERF_W(32)) b1 ();

    branch_predictor_bht #(
        .XLEN(32), .ENTRIES(16), .CTR_W(2), .MODE(BP_BIMODAL), .PERF_W(32)
    ) d0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0.slave)
    );

    branch_predictor_bht #(
        .XLEN(32), .ENTRIES(16), .CTR_W(2), .MODE(BP_GSHARE), .PERF_W(32)
    ) d1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int ifValid, input int ifStall, input int ifPc,
                                 input int updValid, input int updIsBranch, input int updPc,
                                 input int updTaken, input int updTarget,
                                 input int updPredTaken, input int updPredTarget,
                                 input int updGhr);
        b0.if_valid        = 1'(ifValid);
        b0.if_stall        = 1'(ifStall);
        b0.if_pc           = 32'(ifPc);
        b0.upd_valid       = 1'(updValid);
        b0.upd_is_branch   = 1'(updIsBranch);
        b0.upd_pc          = 32'(updPc);
        b0.upd_taken       = 1'(updTaken);
        b0.upd_target      = 32'(updTarget);
        b0.upd_pred_taken  = 1'(updPredTaken);
        b0.upd_pred_target = 32'(updPredTarget);
        b0.upd_ghr         = 4'(updGhr);
        b1.if_valid        = 1'(ifValid);
        b1.if_stall        = 1'(ifStall);
        b1.if_pc           = 32'(ifPc);
        b1.upd_valid       = 1'(updValid);
        b1.upd_is_branch   = 1'(updIsBranch);
        b1.upd_pc          = 32'(updPc);
        b1.upd_taken       = 1'(updTaken);
        b1.upd_target      = 32'(updTarget);
        b1.upd_pred_taken  = 1'(updPredTaken);
        b1.upd_pred_target = 32'(updPredTarget);
        b1.upd_ghr         = 4'(updGhr);
        #1;
    endtask

    task automatic applyLookup(input int pc);
        applyStimulus(0, 0, pc, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        applyLookup(32'h100);
        #11;
        rst_n = 1'b1;

        // Reset state and counting of accepted lookups
        applyStimulus(1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset_hit", b0.pred_hit, 0);
        checkOutput("reset_taken", b0.pred_taken, 0);
        checkOutput("reset_target", b0.pred_target, 32'h104);
        checkOutput("reset_ghr", b0.pred_ghr, 0);
        checkOutput("reset_lookups", b0.perf_lookups, 0);
        checkOutput("reset_mispredicts", b0.perf_mispredicts, 0);
        checkOutput("reset_mispredict", b0.mispredict, 0);
        checkOutput("reset_redirect", b0.redirect_pc, 32'h4);
        tick;
        checkOutput("lookups_one", b0.perf_lookups, 1);
        applyStimulus(1, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        checkOutput("stall_lookups", b0.perf_lookups, 1);

        // Cold taken branch allocates weakly-taken
        applyStimulus(0, 0, 32'h100, 1, 1, 32'h100, 1, 32'h80, 0, 32'h104, 0);
        checkOutput("cold_mispredict", b0.mispredict, 1);
        checkOutput("cold_redirect", b0.redirect_pc, 32'h80);
        checkOutput("cold_hit_pre", b0.pred_hit, 0);
        tick;
        applyLookup(32'h100);
        checkOutput("trained_hit", b0.pred_hit, 1);
        checkOutput("trained_taken", b0.pred_taken, 1);
        checkOutput("trained_target", b0.pred_target, 32'h80);
        checkOutput("mis_count_1", b0.perf_mispredicts, 1);

        // Saturation and hysteresis
        applyStimulus(0, 0, 32'h100, 1, 1, 32'h100, 1, 32'h80, 1, 32'h90, 0);
        checkOutput("wrong_target_mispredict", b0.mispredict, 1);
        tick;
        applyStimulus(0, 0, 32'h100, 1, 1, 32'h100, 1, 32'h80, 1, 32'h80, 0);
        checkOutput("right_target_mispredict", b0.mispredict, 0);
        tick;
        tick;
        applyStimulus(0, 0, 32'h100, 1, 1, 32'h100, 0, 0, 1, 32'h80, 0);
        checkOutput("nt1_mispredict", b0.mispredict, 1);
        checkOutput("nt1_redirect", b0.redirect_pc, 32'h104);
        checkOutput("sat_taken", b0.pred_taken, 1);
        tick;
        applyLookup(32'h100);
        checkOutput("hyst_taken", b0.pred_taken, 1);
        checkOutput("hyst_target", b0.pred_target, 32'h80);
        applyStimulus(0, 0, 32'h100, 1, 1, 32'h100, 0, 0, 1, 32'h80, 0);
        tick;
        applyLookup(32'h100);
        checkOutput("nt2_hit", b0.pred_hit, 1);
        checkOutput("nt2_taken", b0.pred_taken, 0);
        checkOutput("nt2_target", b0.pred_target, 32'h104);
        applyStimulus(0, 0, 32'h100, 1, 1, 32'h100, 0, 0, 0, 32'h104, 0);
        checkOutput("nt3_mispredict", b0.mispredict, 0);
        tick;
        tick;
        applyLookup(32'h100);
        checkOutput("floor_taken", b0.pred_taken, 0);
        applyStimulus(0, 0, 32'h100, 1, 1, 32'h100, 1, 32'h80, 0, 32'h104, 0);
        tick;
        applyLookup(32'h100);
        checkOutput("floor_inc_taken", b0.pred_taken, 0);

        // Same-cycle lookup and update: lookup sees pre-update counter
        applyStimulus(0, 0, 32'h100, 1, 1, 32'h100, 1, 32'h80, 0, 32'h104, 0);
        tick;
        applyStimulus(0, 0, 32'h100, 1, 1, 32'h100, 0, 0, 1, 32'h80, 0);
        checkOutput("collide_taken", b0.pred_taken, 1);
        tick;
        applyLookup(32'h100);
        checkOutput("collide_after_taken", b0.pred_taken, 0);
        checkOutput("mis_count_7", b0.perf_mispredicts, 7);
        checkOutput("lookups_still_1", b0.perf_lookups, 1);
        checkOutput("bimodal_ghr", b0.pred_ghr, 0);

        // Aliasing at index 0
        applyLookup(32'h140);
        checkOutput("alias_hit", b0.pred_hit, 0);
        checkOutput("alias_target", b0.pred_target, 32'h144);
        applyStimulus(0, 0, 32'h140, 1, 1, 32'h140, 1, 32'h200, 0, 32'h144, 0);
        tick;
        applyLookup(32'h100);
        checkOutput("evicted_hit", b0.pred_hit, 0);
        checkOutput("evicted_target", b0.pred_target, 32'h104);
        applyLookup(32'h140);
        checkOutput("alias_new_hit", b0.pred_hit, 1);
        checkOutput("alias_new_target", b0.pred_target, 32'h200);
        applyStimulus(0, 0, 32'h140, 1, 0, 32'h100, 1, 32'h300, 0, 32'h104, 0);
        checkOutput("nonbranch_mispredict", b0.mispredict, 0);
        tick;
        applyStimulus(0, 0, 32'h140, 1, 1, 32'h180, 0, 0, 0, 32'h184, 0);
        tick;
        applyLookup(32'h100);
        checkOutput("nonbranch_hit", b0.pred_hit, 0);
        applyLookup(32'h180);
        checkOutput("nt_miss_hit", b0.pred_hit, 0);
        applyLookup(32'h140);
        checkOutput("entry_kept_hit", b0.pred_hit, 1);
        checkOutput("entry_kept_target", b0.pred_target, 32'h200);
        checkOutput("mis_count_8", b0.perf_mispredicts, 8);

        // Asynchronous reset discards training
        rst_n = 1'b0;
        #1;
        checkOutput("rst_hit", b0.pred_hit, 0);
        checkOutput("rst_mispredicts", b0.perf_mispredicts, 0);
        checkOutput("rst_lookups", b0.perf_lookups, 0);
        #1;
        rst_n = 1'b1;

        // Gshare: train entries 0,1,3,7 without mispredicting
        applyStimulus(0, 0, 32'h100, 1, 1, 32'h100, 1, 32'h80, 1, 32'h80, 4'h0);
        checkOutput("gs_train_mispredict", b1.mispredict, 0);
        tick;
        applyStimulus(0, 0, 32'h100, 1, 1, 32'h100, 1, 32'h80, 1, 32'h80, 4'h1);
        tick;
        applyStimulus(0, 0, 32'h100, 1, 1, 32'h100, 1, 32'h80, 1, 32'h80, 4'h3);
        tick;
        applyStimulus(0, 0, 32'h100, 1, 1, 32'h100, 1, 32'h80, 1, 32'h80, 4'h7);
        tick;
        applyStimulus(1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("gs_ghr0", b1.pred_ghr, 4'h0);
        checkOutput("gs_hit0", b1.pred_hit, 1);
        checkOutput("gs_target0", b1.pred_target, 32'h80);
        tick;
        checkOutput("gs_ghr1", b1.pred_ghr, 4'h1);
        checkOutput("gs_hit1", b1.pred_hit, 1);
        tick;
        checkOutput("gs_ghr3", b1.pred_ghr, 4'h3);
        tick;
        checkOutput("gs_ghr7", b1.pred_ghr, 4'h7);
        applyStimulus(1, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("gs_stall_hit", b1.pred_hit, 1);
        tick;
        checkOutput("gs_stall_ghr", b1.pred_ghr, 4'h7);
        applyStimulus(1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        checkOutput("gs_ghrF", b1.pred_ghr, 4'hF);
        checkOutput("gs_lookups", b1.perf_lookups, 4);

        // Mispredict restores history over a same-cycle predicted-taken fetch
        applyStimulus(1, 0, 32'h13C, 1, 1, 32'h100, 0, 0, 1, 32'h80, 4'h2);
        checkOutput("gs_fetch_hit", b1.pred_hit, 1);
        checkOutput("gs_mispredict", b1.mispredict, 1);
        checkOutput("gs_redirect", b1.redirect_pc, 32'h104);
        tick;
        checkOutput("gs_restore_ghr", b1.pred_ghr, 4'h4);
        checkOutput("gs_mis_count", b1.perf_mispredicts, 1);

        rst_n = 1'b0;
        #1;
        checkOutput("gs_rst_ghr", b1.pred_ghr, 0);
        checkOutput("gs_rst_lookups", b1.perf_lookups, 0);
        checkOutput("gs_rst_mispredicts", b1.perf_mispredicts, 0);
        #1;
        rst_n = 1'b1;
        applyLookup(32'h100);
        checkOutput("gs_post_rst_hit", b1.pred_hit, 0);
        checkOutput("gs_post_rst_target", b1.pred_target, 32'h104);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/branch_predictor_bht.md
Name: branch_predictor_bht

Overview:
- Parametrised dynamic branch predictor replacing the static predict-not-taken / flush-on-taken scheme.
- Direct-mapped branch target buffer with per-entry saturating counters. Two indexing modes: bimodal and gshare.
- IF-stage lookup feeds next-PC selection. The EX/MEM resolution port trains the table and raises mispredict and a redirect PC for the pipeline flush.
- Counts lookups and mispredicts for performance monitoring.

Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 16, table depth; power of two, ≥ 2. IDX_W = log2(ENTRIES).
- CTR_W, 2, saturating counter width; ≥ 2.
- MODE, 0, 0 = bimodal (index = pc[IDX_W+1:2]), 1 = gshare (index = pc[IDX_W+1:2] XOR ghr).
- PERF_W, 32, performance counter width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_valid  in  1  fetch lookup valid
- if_stall  in  1  fetch stalled (hazard stall); blocks speculative GHR update
- if_pc  in  XLEN  fetch PC
- pred_hit  out  1  tag match on a valid entry
- pred_taken  out  1  predicted taken
- pred_target  out  XLEN  predicted next PC
- pred_ghr  out  IDX_W  GHR snapshot, carried down the pipe with the instruction
- upd_valid  in  1  resolution valid
- upd_is_branch  in  1  resolved instruction is a conditional branch
- upd_pc  in  XLEN  branch PC
- upd_taken  in  1  actual outcome
- upd_target  in  XLEN  actual taken target
- upd_pred_taken  in  1  prediction carried with the branch
- upd_pred_target  in  XLEN  predicted target carried with the branch
- upd_ghr  in  IDX_W  GHR snapshot carried with the branch
- mispredict  out  1  flush request
- redirect_pc  out  XLEN  correct next PC
- perf_lookups  out  PERF_W  accepted lookups, saturating
- perf_mispredicts  out  PERF_W  mispredicts, saturating

Behaviour:
- Entry fields: valid, tag = pc[XLEN-1:IDX_W+2], target[XLEN], ctr[CTR_W].
- Reset (rst=0, asynchronous):
  - All valid=0, ctr = weakly-not-taken (MSB 0, other bits 1; 2'b01).
  - ghr=0, both perf counters 0.
  - Outputs: pred_hit=0, pred_taken=0, mispredict=0. pred_target = if_pc+4 and redirect_pc = upd_pc+4 (combinational).
  - Reset asserted mid-training discards all state.
- Lookup (combinational from registered state, 0-cycle latency):
  - idx is computed per MODE; pred_hit = valid[idx] && tag match.
  - pred_taken = pred_hit && ctr[idx][MSB].
  - pred_target = pred_taken ? target[idx] : if_pc+4, modulo 2^XLEN.
  - pred_ghr = ghr.
- Resolution (combinational outputs):
  - mispredict = upd_valid && upd_is_branch && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target)).
  - redirect_pc = upd_taken ? upd_target : upd_pc+4.
- Training (clock edge, when upd_valid && upd_is_branch). Index uses upd_pc, plus upd_ghr in MODE 1.
  - Tag hit: ctr saturating inc if taken, dec if not taken (no wrap at all-ones/zero). target <= upd_target if taken.
  - Tag miss and taken: allocate/overwrite. valid=1, tag, target, ctr = weakly-taken (MSB 1, others 0; 2'b10).
  - Tag miss and not taken: no change.
  - upd_valid && !upd_is_branch: no table change, mispredict=0.
- GHR (MODE 1 only; held at 0 in MODE 0):
  - Priority 1, mispredict: ghr <= {upd_ghr[IDX_W-2:0], upd_taken} (restore plus actual outcome).
  - Priority 2, else if if_valid && !if_stall && pred_hit: ghr <= {ghr[IDX_W-2:0], pred_taken}.
  - Otherwise hold.
- Simultaneous lookup and update to the same index: lookup returns pre-update state (no bypass). The update takes effect next cycle.
- Performance counters:
  - perf_lookups increments on if_valid && !if_stall.
  - perf_mispredicts increments on mispredict.
  - Both saturate at all-ones.

Decomposition:
- Package bp_pkg holds:
  - the counter typedef;
  - constants CTR_WNT and CTR_WT, derived from CTR_W;
  - functions sat_inc / sat_dec;
  - the MODE enum (BP_BIMODAL, BP_GSHARE).
- Sub-module bp_entry_table: storage arrays, async reset, one combinational read port, one write port.
- The top contains the index/tag hashing, GHR, mispredict logic and perf counters.

Test Plan (ENTRIES=16, CTR_W=2 unless stated):
1. Reset, then lookup if_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104, pred_ghr=0, perf counters 0.
2. Cold taken branch, MODE 0: update pc=0x100, taken, target=0x80, pred_taken=0 -> mispredict=1, redirect_pc=0x80. Next-cycle lookup 0x100 -> hit=1, taken=1, target=0x80.
3. Saturation and hysteresis:
   - 3 further taken updates on 0x100 -> ctr=11.
   - 1 not-taken update -> still predicts taken.
   - 2nd not-taken update -> pred_taken=0, target=0x104.
   - 3rd and 4th not-taken -> ctr stays 00.
4. Aliasing: with 0x100 trained, lookup 0x140 (same idx 0, different tag) -> hit=0. Taken update on 0x140 (target 0x200) overwrites the entry; lookup 0x100 now misses.
5. Same-cycle collision: lookup 0x100 while updating 0x100 not-taken from ctr=10 -> this cycle pred_taken=1, next cycle pred_taken=0.
6. MODE=1 GHR:
   - 4 predicted-taken hits -> ghr=1111; an if_stall cycle holds ghr.
   - Mispredict with upd_ghr=0010, upd_taken=0 -> ghr=0100 next cycle; perf_mispredicts increments by 1.
   - Assert rst mid-sequence -> all cleared.
